// File: rtl/seq_div_pkg.sv
// ---------------------------------------------------------------------------
// seq_div_pkg
// Shared widths and FSM state type for the sequential 16/8 restoring divider.
// No ports (package).
//   DIVIDEND_W : dividend width (16)
//   DIVISOR_W  : divisor, quotient and remainder width (8)
//   CNT_W      : width of the quotient-bit counter (3, counts 7 down to 0)
//   state_t    : IDLE (accepting), BUSY (iterating), DONE (result held)
// ---------------------------------------------------------------------------
package seq_div_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int CNT_W      = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_div_step.sv
// ---------------------------------------------------------------------------
// seq_div_step
// One combinational restoring-division iteration.
//   p_in   in  8  low byte of the partial remainder P
//   bit_in in  1  next dividend bit shifted in
//   d      in  8  divisor D
//   p_out  out 8  low byte of the new partial remainder
//   q_bit  out 1  quotient bit produced by this iteration
// ---------------------------------------------------------------------------
module seq_div_step
    import seq_div_pkg::*;
(
    input  logic [DIVISOR_W-1:0] p_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] d,
    output logic [DIVISOR_W-1:0] p_out,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] trial;

    // Only P[7:0] ever feeds the next trial value, so bit 8 of the new P is
    // never needed: the low byte of T - D is computed directly in 8 bits,
    // while the compare still uses the full 9-bit T.
    always_comb begin
        trial = {p_in, bit_in};
        if (trial >= {1'b0, d}) begin
            p_out = trial[DIVISOR_W-1:0] - d;
            q_bit = 1'b1;
        end else begin
            p_out = trial[DIVISOR_W-1:0];
            q_bit = 1'b0;
        end
    end

endmodule

// File: rtl/seq_div_16_8.sv
// ---------------------------------------------------------------------------
// seq_div_16_8
// Sequential restoring divider: 16-bit dividend / 8-bit divisor -> 8-bit
// quotient and 8-bit remainder, one quotient bit per clock, with valid/ready
// handshakes on input and output. All outputs are registered.
//   clk       in  1   clock, rising edge
//   rst       in  1   synchronous reset, active high
//   in_valid  in  1   dividend/divisor valid
//   in_ready  out 1   block can accept an operation (IDLE)
//   dividend  in  16  unsigned dividend N
//   divisor   in  8   unsigned divisor D
//   out_valid out 1   result valid (DONE)
//   out_ready in  1   downstream accepts the result
//   quotient  out 8   Q
//   remainder out 8   R
//   ovf       out 1   overflow / divide-by-zero flag
// Optional feature macro: SEQ_DIV_OVF_DETECT_EN
//   When defined, D = 0 or N[15:8] >= D is detected at accept; the block
//   spends a single cycle in BUSY and returns Q = 8'hFF, R = N[7:0], ovf = 1.
//   When undefined, ovf is tied to 0 and every operation iterates 8 times.
// ---------------------------------------------------------------------------
module seq_div_16_8
    import seq_div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVISOR_W-1:0]  quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  ovf
);

    state_t               state_q, state_d;
    logic [DIVISOR_W-1:0] p_q, p_d;
    logic [DIVISOR_W-1:0] s_q, s_d;
    logic [DIVISOR_W-1:0] d_q, d_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIVISOR_W-1:0] q_acc_q, q_acc_d;
    logic [DIVISOR_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0] remainder_q, remainder_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;

    logic [DIVISOR_W-1:0] step_p;
    logic                 step_q;

`ifdef SEQ_DIV_OVF_DETECT_EN
    logic ovf_pend_q, ovf_pend_d;
    logic ovf_q, ovf_d;
`endif

    seq_div_step u_step (
        .p_in   (p_q),
        .bit_in (s_q[DIVISOR_W-1]),
        .d      (d_q),
        .p_out  (step_p),
        .q_bit  (step_q)
    );

    // Next-state logic. Only P[7:0] is stored because bit 8 of P never
    // reaches the next trial value or the remainder. The handshake outputs
    // are derived from the next state so they come straight out of flops.
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        s_d         = s_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        q_acc_d     = q_acc_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
`ifdef SEQ_DIV_OVF_DETECT_EN
        ovf_pend_d  = ovf_pend_q;
        ovf_d       = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    d_d     = divisor;
                    p_d     = dividend[DIVIDEND_W-1:DIVISOR_W];
                    s_d     = dividend[DIVISOR_W-1:0];
                    cnt_d   = '1;
                    q_acc_d = '0;
                    state_d = BUSY;
`ifdef SEQ_DIV_OVF_DETECT_EN
                    ovf_pend_d = (divisor == '0) ||
                                 (dividend[DIVIDEND_W-1:DIVISOR_W] >= divisor);
`endif
                end
            end

            BUSY: begin
`ifdef SEQ_DIV_OVF_DETECT_EN
                // Flagged operations leave after one cycle; S still holds
                // N[7:0] because no iteration has shifted it yet.
                if (ovf_pend_q) begin
                    quotient_d  = '1;
                    remainder_d = s_q;
                    ovf_d       = 1'b1;
                    state_d     = DONE;
                end else begin
`endif
                    s_d              = s_q << 1;
                    p_d              = step_p;
                    q_acc_d[cnt_q]   = step_q;
                    if (cnt_q == '0) begin
                        quotient_d  = q_acc_d;
                        remainder_d = step_p;
                        state_d     = DONE;
`ifdef SEQ_DIV_OVF_DETECT_EN
                        ovf_d       = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
`ifdef SEQ_DIV_OVF_DETECT_EN
                end
`endif
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            p_q         <= '0;
            s_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            q_acc_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SEQ_DIV_OVF_DETECT_EN
            ovf_pend_q  <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            s_q         <= s_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            q_acc_q     <= q_acc_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SEQ_DIV_OVF_DETECT_EN
            ovf_pend_q  <= ovf_pend_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
`ifdef SEQ_DIV_OVF_DETECT_EN
    assign ovf       = ovf_q;
`else
    assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_seq_div_16_8.sv
// ---------------------------------------------------------------------------
// tb_seq_div_16_8
// Self-checking bench for seq_div_16_8: directed cases (exact-product
// inversion, remainder, divide-by-zero, overflow, backpressure, reset during
// BUSY, throughput) followed by a randomized sweep with random out_ready
// stalls. A driver pushes expected results into a scoreboard queue; an
// independent monitor pops and compares whenever a result is presented.
// Honors SEQ_DIV_OVF_DETECT_EN in the reference model.
// ---------------------------------------------------------------------------
module tb_seq_div_16_8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        ovf;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       ovf;
        int         lat;
        longint     acc;
    } exp_t;

    exp_t   sb[$];
    int     compared   = 0;
    int     mismatched = 0;
    longint cycle      = 0;
    int     stall_mode = 0;

    bit         seen = 1'b0;
    logic [7:0] held_q, held_r;

    seq_div_16_8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf)
    );

    // Free-running clock and cycle counter used for latency measurement.
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Watchdog so the run always ends even if the DUT locks up.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: restoring division in plain integer arithmetic, one
    // quotient bit per dividend low-byte bit, MSB first.
    function automatic exp_t model(input logic [15:0] n, input logic [7:0] d);
        exp_t e;
        int   p;
        int   t;
        e.q = 8'h00;
        p   = int'(n[15:8]);
        for (int i = 7; i >= 0; i--) begin
            t = (p % 256) * 2 + int'(n[i]);
            if (t >= int'(d)) begin
                p      = t - int'(d);
                e.q[i] = 1'b1;
            end else begin
                p = t;
            end
        end
        e.r   = 8'(p % 256);
        e.ovf = 1'b0;
        e.lat = 8;
`ifdef SEQ_DIV_OVF_DETECT_EN
        if (d == 8'h00 || n[15:8] >= d) begin
            e.q   = 8'hFF;
            e.r   = n[7:0];
            e.ovf = 1'b1;
            e.lat = 1;
        end
`endif
        e.acc = 0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Presents one operation starting at a falling edge, waits for in_ready
    // and pushes the expected result; returns at the falling edge after the
    // accept edge with in_valid dropped.
    task automatic applyStimulus(input logic [15:0] n, input logic [7:0] d,
                                 input bit push, input bit explicit_exp,
                                 input logic [7:0] eq, input logic [7:0] er,
                                 output longint acc);
        exp_t e;
        int   k;
        in_valid = 1'b1;
        dividend = n;
        divisor  = d;
        k = 0;
        while (!in_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 0, 1);
            in_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cycle + 1;
        if (push) begin
            e = model(n, d);
            if (explicit_exp) begin
                e.q = eq;
                e.r = er;
            end
            e.acc = acc;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int k;
        k = 0;
        while ((sb.size() != 0 || out_valid) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0 || out_valid) checkOutput("drain_timeout", 1, 0);
    endtask

    // Monitor: compares each presented result against the scoreboard head,
    // checks that held results stay stable, and drives out_ready stalls.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            seen = 1'b0;
        end else begin
            if (out_valid) begin
                checkOutput("ready_valid_exclusive", in_ready, 0);
                if (!seen) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_result", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("quotient", quotient, e.q);
                        checkOutput("remainder", remainder, e.r);
                        checkOutput("ovf", ovf, e.ovf);
                        checkOutput("latency", cycle - e.acc, e.lat);
                    end
                    seen   = 1'b1;
                    held_q = quotient;
                    held_r = remainder;
                end else begin
                    checkOutput("hold_quotient", quotient, held_q);
                    checkOutput("hold_remainder", remainder, held_r);
                end
            end else begin
                seen = 1'b0;
            end
            if (stall_mode == 0) out_ready = 1'b1;
            else if (stall_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        longint acc1, acc2;
        logic [7:0]  snap_q, snap_r;
        logic [15:0] rn;
        logic [7:0]  rd, hi;
        bit          stable_ok, ready_low_ok, valid_low_ok;
        int          k, sel;

        rst       = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b0;
        $display("[TB] starting seq_div_16_8 bench");

        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_quotient", quotient, 0);
        checkOutput("rst_remainder", remainder, 0);
        checkOutput("rst_ovf", ovf, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("in_ready_after_rst", in_ready, 1);

        // Exact-product inversion and remainder case back to back, which
        // also measures throughput with out_ready held high.
        stall_mode = 0;
        applyStimulus(16'd28743, 8'd201, 1'b1, 1'b1, 8'd143, 8'd0, acc1);
        applyStimulus(16'd1000, 8'd7, 1'b1, 1'b1, 8'd142, 8'd6, acc2);
        checkOutput("throughput_gap", acc2 - acc1, 10);
        waitDrain();

        // Divide by zero and a quotient-overflow case.
        applyStimulus(16'h12AB, 8'd0, 1'b1, 1'b1, 8'hFF, 8'hAB, acc1);
        waitDrain();
        applyStimulus(16'hF00F, 8'h10, 1'b1, 1'b0, 8'h00, 8'h00, acc1);
        waitDrain();

        // Backpressure: hold out_ready low for 20 cycles after the result.
        stall_mode = 2;
        out_ready  = 1'b0;
        applyStimulus(16'd1000, 8'd7, 1'b1, 1'b1, 8'd142, 8'd6, acc1);
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        checkOutput("bp_result_presented", out_valid, 1);
        snap_q = quotient;
        snap_r = remainder;
        stable_ok    = 1'b1;
        ready_low_ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (quotient != snap_q || remainder != snap_r || !out_valid) stable_ok = 1'b0;
            if (in_ready) ready_low_ok = 1'b0;
        end
        checkOutput("bp_outputs_stable", stable_ok, 1);
        checkOutput("bp_in_ready_low", ready_low_ok, 1);
        checkOutput("bp_quotient", snap_q, 142);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_in_ready_after_consume", in_ready, 1);
        checkOutput("bp_out_valid_after_consume", out_valid, 0);
        stall_mode = 0;
        waitDrain();

        // Reset during BUSY: discard the operation, then run a fresh one.
        applyStimulus(16'h5A5A, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00, acc1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_quotient", quotient, 0);
        checkOutput("midrst_remainder", remainder, 0);
        checkOutput("midrst_in_ready", in_ready, 0);
        checkOutput("midrst_ovf", ovf, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_in_ready_after", in_ready, 1);
        valid_low_ok = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) valid_low_ok = 1'b0;
        end
        checkOutput("midrst_no_result", valid_low_ok, 1);
        applyStimulus(16'd255, 8'd16, 1'b1, 1'b1, 8'd15, 8'd15, acc1);
        waitDrain();

        // Randomized sweep with random out_ready stalls and occasional gaps.
        stall_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 9);
            rn  = 16'($urandom);
            if (sel == 0) begin
                rd = 8'd0;
            end else if (sel <= 2) begin
                rd = 8'($urandom_range(1, 255));
                hi = 8'($urandom_range(int'(rd), 255));
                rn[15:8] = hi;
            end else begin
                rd = 8'($urandom_range(1, 255));
                hi = 8'($urandom_range(0, int'(rd) - 1));
                rn[15:8] = hi;
            end
            applyStimulus(rn, rd, 1'b1, 1'b0, 8'h00, 8'h00, acc1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        stall_mode = 0;
        waitDrain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
